mem_port_arbiter: RTL and testbench

//  Shares the single data-RAM port (512x16, 1-cycle synchronous read) between the
//  two memory-write pipeline stages. Pipe A always holds the older instruction.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one 512x16 synchronous RAM port between two memory pipes (A older than B).
// Optional conflict counter enabled by defining MEMARB_CONFLICT_CNT_EN.
module mem_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic {IDLE, HOLD_B} state_t;

    state_t            state, state_next;
    logic              hold_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic              tag_read, tag_is_b;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_wdata;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;

    logic              issue, issue_we, issue_b, capture_b;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_wdata;

    always_comb begin
        state_next  = state;
        issue       = 1'b0;
        issue_we    = 1'b0;
        issue_b     = 1'b0;
        issue_addr  = last_addr;
        issue_wdata = last_wdata;
        capture_b   = 1'b0;
        stall       = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_a) begin
                        issue       = 1'b1;
                        issue_we    = we_a;
                        issue_addr  = addr_a;
                        issue_wdata = wdata_a;
                        if (req_b) begin
                            capture_b  = 1'b1;
                            stall      = 1'b1;
                            state_next = HOLD_B;
                        end
                    end else if (req_b) begin
                        issue       = 1'b1;
                        issue_b     = 1'b1;
                        issue_we    = we_b;
                        issue_addr  = addr_b;
                        issue_wdata = wdata_b;
                    end
                end
                // Upstream is frozen here, so the live req_* inputs are only repeats.
                HOLD_B: begin
                    issue       = 1'b1;
                    issue_b     = 1'b1;
                    issue_we    = hold_we;
                    issue_addr  = hold_addr;
                    issue_wdata = hold_wdata;
                    state_next  = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign ram_en    = issue;
    assign ram_we    = issue & issue_we;
    assign ram_addr  = issue_addr;
    assign ram_wdata = issue_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            tag_read   <= 1'b0;
            tag_is_b   <= 1'b0;
        end else begin
            state    <= state_next;
            tag_read <= issue & ~issue_we;
            tag_is_b <= issue_b;
            if (capture_b) begin
                hold_we    <= we_b;
                hold_addr  <= addr_b;
                hold_wdata <= wdata_b;
            end
        end
    end

    // Address and data lines keep their last driven value while the port is idle.
    always_ff @(posedge clk) begin
        if (issue) begin
            last_addr  <= issue_addr;
            last_wdata <= issue_wdata;
        end
    end

    assign rvalid_a = tag_read & ~tag_is_b & ~rst;
    assign rvalid_b = tag_read &  tag_is_b & ~rst;
    assign rdata_a  = rvalid_a ? ram_rdata : rdata_a_q;
    assign rdata_b  = rvalid_b ? ram_rdata : rdata_b_q;

    always_ff @(posedge clk) begin
        if (rvalid_a) rdata_a_q <= ram_rdata;
        if (rvalid_b) rdata_b_q <= ram_rdata;
    end

`ifdef MEMARB_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (capture_b && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign conflict_cnt = rst ? '0 : cnt_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based transaction model and a RAM model.
// Counter expectations follow MEMARB_CONFLICT_CNT_EN when defined.
module tb_mem_port_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              rvalid_a, rvalid_b, stall;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [CNT_W-1:0]  conflict_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_a(rdata_a), .rvalid_a(rvalid_a), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
        .stall(stall), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
    );

    // Physical RAM driven by the DUT port
    logic [DATA_W-1:0] ram [0:511];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              is_b;
    } req_t;

    req_t              pendQ[$];
    logic [DATA_W-1:0] refMem [0:511];
    logic              retPending, retIsB, haveLast, haveRdA, haveRdB;
    logic [DATA_W-1:0] retData, lastRdA, lastRdB;
    logic [ADDR_W-1:0] lastAddr;
    int                refCnt;
    int                testCount, failCount;
    logic [DATA_W-1:0] orig1ff;

    task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, predict from the transaction queue, check, then commit.
    task applyStimulus(input logic r, input logic ra, input logic wa, input logic [ADDR_W-1:0] aa,
                       input logic [DATA_W-1:0] da, input logic rb, input logic wb,
                       input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
        req_t entries[$];
        req_t cur;
        logic conflict, va, vb;
        rst = r; req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        entries = {};
        if (pendQ.size() != 0) entries = pendQ;
        else begin
            if (ra) entries.push_back(req_t'{wa, aa, da, 1'b0});
            if (rb) entries.push_back(req_t'{wb, ab, db, 1'b1});
        end
        conflict = !r && (pendQ.size() == 0) && ra && rb;
        va = !r && retPending && !retIsB;
        vb = !r && retPending && retIsB;
        @(negedge clk);
        if (r) begin
            checkOutput("rst_ram_en", ram_en, 0);
            checkOutput("rst_ram_we", ram_we, 0);
            checkOutput("rst_stall", stall, 0);
            checkOutput("rst_rvalid_a", rvalid_a, 0);
            checkOutput("rst_rvalid_b", rvalid_b, 0);
            checkOutput("rst_cnt", conflict_cnt, 0);
        end else begin
            checkOutput("ram_en", ram_en, entries.size() != 0);
            checkOutput("stall", stall, entries.size() > 1);
            if (entries.size() != 0) begin
                cur = entries[0];
                checkOutput("ram_we", ram_we, cur.we);
                checkOutput("ram_addr", ram_addr, cur.addr);
                if (cur.we) checkOutput("ram_wdata", ram_wdata, cur.data);
            end else begin
                checkOutput("ram_we_idle", ram_we, 0);
                if (haveLast) checkOutput("ram_addr_hold", ram_addr, lastAddr);
            end
            checkOutput("rvalid_a", rvalid_a, va);
            checkOutput("rvalid_b", rvalid_b, vb);
            if (va) checkOutput("rdata_a", rdata_a, retData);
            else if (haveRdA) checkOutput("rdata_a_hold", rdata_a, lastRdA);
            if (vb) checkOutput("rdata_b", rdata_b, retData);
            else if (haveRdB) checkOutput("rdata_b_hold", rdata_b, lastRdB);
`ifdef MEMARB_CONFLICT_CNT_EN
            checkOutput("conflict_cnt", conflict_cnt, refCnt);
`else
            checkOutput("conflict_cnt_off", conflict_cnt, 0);
`endif
        end
        if (r) begin
            pendQ.delete();
            retPending = 1'b0;
            refCnt = 0;
        end else begin
            if (va) begin lastRdA = retData; haveRdA = 1'b1; end
            if (vb) begin lastRdB = retData; haveRdB = 1'b1; end
            retPending = 1'b0;
            if (entries.size() != 0) begin
                cur = entries.pop_front();
                lastAddr = cur.addr;
                haveLast = 1'b1;
                if (cur.we) refMem[cur.addr] = cur.data;
                else begin
                    retPending = 1'b1;
                    retIsB = cur.is_b;
                    retData = refMem[cur.addr];
                end
            end
            pendQ = entries;
            if (conflict && refCnt < (1 << CNT_W) - 1) refCnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        testCount = 0; failCount = 0;
        retPending = 0; retIsB = 0; retData = 0; haveLast = 0; haveRdA = 0; haveRdB = 0;
        lastAddr = 0; lastRdA = 0; lastRdB = 0; refCnt = 0;
        for (int i = 0; i < 512; i++) begin
            v = DATA_W'($urandom);
            ram[i] = v;
            refMem[i] = v;
        end
        ram[9'h010] = 16'hBEEF;
        refMem[9'h010] = 16'hBEEF;
        orig1ff = ram[9'h1FF];

        applyStimulus(1, 1, 1, 9'h001, 16'h1111, 1, 1, 9'h002, 16'h2222);
        applyStimulus(1, 1, 1, 9'h001, 16'h1111, 1, 1, 9'h002, 16'h2222);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 1, 9'h005, 16'h1234, 0, 0, 0, 0);

        applyStimulus(0, 1, 0, 9'h010, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rdata_a_beef", rdata_a, 16'hBEEF);

        applyStimulus(0, 1, 1, 9'h020, 16'h00AA, 1, 0, 9'h020, 0);
        applyStimulus(0, 1, 1, 9'h020, 16'h00AA, 1, 0, 9'h020, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rdata_b_00aa", rdata_b, 16'h00AA);

        applyStimulus(0, 1, 0, 9'h030, 0, 1, 1, 9'h1FF, 16'h5555);
        applyStimulus(1, 1, 0, 9'h030, 0, 1, 1, 9'h1FF, 16'h5555);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ram_1ff_kept", ram[9'h1FF], orig1ff);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 1, 9'(i), 16'(i), 1, 0, 9'(i + 1), 0);
            applyStimulus(0, 1, 1, 9'(i), 16'(i), 1, 0, 9'(i + 1), 0);
        end

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 59) == 0,
                          1'($urandom), 1'($urandom), 9'($urandom_range(0, 7)), 16'($urandom),
                          1'($urandom), 1'($urandom),
                          ($urandom_range(0, 9) == 0) ? 9'h1FF : 9'($urandom_range(0, 7)),
                          16'($urandom));
        end

        for (int i = 0; i < 512; i++) begin
            if (ram[i] !== refMem[i]) checkOutput("ram_final", ram[i], refMem[i]);
        end
        checkOutput("ram_final_1ff", ram[9'h1FF], refMem[9'h1FF]);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
